// File: rtl/ysyx_24110006_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_mem_arbiter_if
//
// Purpose:
//   Downstream memory bus shared by the IFU and LSU through the arbiter.
//   Carries one request (valid/ready handshake plus latched request fields)
//   and one response strobe with read data and an error flag.
//
// Signals:
//   req_valid  request valid            (master -> slave)
//   req_ready  request accepted         (slave  -> master)
//   addr       request address, 32 bit  (master -> slave)
//   wen        1 = store, 0 = load      (master -> slave)
//   wdata      store data, 32 bit       (master -> slave)
//   wmask      byte strobes, 4 bit      (master -> slave)
//   rsp_valid  response strobe          (slave  -> master)
//   rdata      read data, 32 bit        (slave  -> master)
//   rsp_err    bus error                (slave  -> master)
//
// Modports:
//   master  the arbiter side that issues requests
//   slave   the memory / crossbar side that answers them
// ---------------------------------------------------------------------------
interface ysyx_24110006_mem_arbiter_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    output addr,
    output wen,
    output wdata,
    output wmask,
    input  req_ready,
    input  rsp_valid,
    input  rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  addr,
    input  wen,
    input  wdata,
    input  wmask,
    output req_ready,
    output rsp_valid,
    output rdata,
    output rsp_err
  );

endinterface

// File: rtl/ysyx_24110006_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_mem_arbiter
//
// Purpose:
//   Shares a single memory bus port between the IFU (instruction fetch,
//   read only) and the LSU (loads and stores). Only one transaction is in
//   flight at a time. A grant is issued per transaction, the request fields
//   are latched and presented downstream, and the registered response is
//   routed back to whichever requester owns the transaction.
//
// Optional feature (compile-time macro ARB_RR_EN):
//   defined    round-robin on simultaneous requests: the requester that was
//              not granted last wins (after reset the last grant counts as
//              IFU, so the first tie goes to the LSU)
//   undefined  fixed priority: the LSU always wins a tie
//   A lone requester is granted immediately in both modes.
//
// Parameters:
//   TIMEOUT  cycles spent waiting for a response before the owner gets an
//            error response; 0 disables the timeout
//   CNT_W    width of the timeout counter, must be able to hold TIMEOUT
//
// Ports:
//   i_clock          clock
//   i_reset          synchronous, active-high reset
//   i_ifu_req_valid  IFU read request
//   o_ifu_req_ready  IFU request accepted this cycle
//   i_ifu_addr       IFU fetch address
//   o_ifu_rsp_valid  one-cycle IFU response strobe
//   o_ifu_rdata      IFU read data
//   o_ifu_rsp_err    IFU bus error / timeout
//   i_lsu_req_valid  LSU request
//   o_lsu_req_ready  LSU request accepted this cycle
//   i_lsu_addr       LSU address
//   i_lsu_wen        1 = store, 0 = load
//   i_lsu_wdata      store data
//   i_lsu_wmask      byte strobes (store only)
//   o_lsu_rsp_valid  one-cycle LSU response strobe
//   o_lsu_rdata      load data (0 for stores)
//   o_lsu_rsp_err    LSU bus error / timeout
//   mem              downstream memory bus (master side)
// ---------------------------------------------------------------------------
module ysyx_24110006_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,

  input  logic        i_ifu_req_valid,
  output logic        o_ifu_req_ready,
  input  logic [31:0] i_ifu_addr,
  output logic        o_ifu_rsp_valid,
  output logic [31:0] o_ifu_rdata,
  output logic        o_ifu_rsp_err,

  input  logic        i_lsu_req_valid,
  output logic        o_lsu_req_ready,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_wen,
  input  logic [31:0] i_lsu_wdata,
  input  logic [3:0]  i_lsu_wmask,
  output logic        o_lsu_rsp_valid,
  output logic [31:0] o_lsu_rdata,
  output logic        o_lsu_rsp_err,

  ysyx_24110006_mem_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RSP   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic             TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  owner_t           owner;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic             grant_ifu;
  logic             grant_lsu;
  logic             grant_any;
  logic             rsp_fire;
  logic             timeout_hit;

  logic [31:0]      addr_q;
  logic             wen_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wmask_q;

`ifdef ARB_RR_EN
  owner_t           last_grant;
`endif

  // Grant decision. Grants are only possible in IDLE and never while reset
  // is asserted, so every output reads 0 during reset even if a requester
  // is already holding its valid high.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE && !i_reset) begin
      if (i_ifu_req_valid && i_lsu_req_valid) begin
`ifdef ARB_RR_EN
        if (last_grant == OWN_IFU) begin
          grant_lsu = 1'b1;
        end else begin
          grant_ifu = 1'b1;
        end
`else
        grant_lsu = 1'b1;
`endif
      end else begin
        grant_ifu = i_ifu_req_valid;
        grant_lsu = i_lsu_req_valid;
      end
    end
  end

  assign grant_any       = grant_ifu | grant_lsu;
  assign o_ifu_req_ready = grant_ifu;
  assign o_lsu_req_ready = grant_lsu;

  // A response is only meaningful while waiting in RSP; strobes seen in any
  // other state are dropped (DRAIN consumes its one late strobe silently).
  // The timeout fires on the TIMEOUT-th RSP cycle without a response; a
  // response arriving in that same cycle takes precedence.
  assign cnt_inc     = cnt + CNT_W'(1);
  assign rsp_fire    = (state == S_RSP) && mem.rsp_valid;
  assign timeout_hit = TIMEOUT_EN && (state == S_RSP) && !mem.rsp_valid &&
                       (cnt_inc == TIMEOUT_CNT);

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.req_ready) begin
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (mem.rsp_valid) begin
          state_nxt = S_IDLE;
        end else if (timeout_hit) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem.rsp_valid) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request latch and owner tracking. IFU fetches are presented as plain
  // reads with zeroed store fields.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      owner   <= OWN_IFU;
      addr_q  <= 32'd0;
      wen_q   <= 1'b0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
    end else if (grant_lsu) begin
      owner   <= OWN_LSU;
      addr_q  <= i_lsu_addr;
      wen_q   <= i_lsu_wen;
      wdata_q <= i_lsu_wdata;
      wmask_q <= i_lsu_wmask;
    end else if (grant_ifu) begin
      owner   <= OWN_IFU;
      addr_q  <= i_ifu_addr;
      wen_q   <= 1'b0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
    end
  end

`ifdef ARB_RR_EN
  // Remembers who won the most recent grant so the next tie goes the
  // other way.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_grant <= OWN_IFU;
    end else if (grant_lsu) begin
      last_grant <= OWN_LSU;
    end else if (grant_ifu) begin
      last_grant <= OWN_IFU;
    end
  end
`endif

  // Timeout counter: cleared when the request is accepted downstream and
  // advanced once per cycle spent waiting in RSP.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (state == S_REQ && mem.req_ready) begin
      cnt <= '0;
    end else if (state == S_RSP) begin
      cnt <= cnt_inc;
    end
  end

  // Response registers. The strobes are single-cycle pulses; data and error
  // are held until that requester's next response so that one side's
  // outputs never move when the other side is served. Stores return 0 as
  // read data, and a timeout returns 0 with the error flag set.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ifu_rsp_valid <= 1'b0;
      o_ifu_rdata     <= 32'd0;
      o_ifu_rsp_err   <= 1'b0;
      o_lsu_rsp_valid <= 1'b0;
      o_lsu_rdata     <= 32'd0;
      o_lsu_rsp_err   <= 1'b0;
    end else begin
      o_ifu_rsp_valid <= 1'b0;
      o_lsu_rsp_valid <= 1'b0;
      if (rsp_fire || timeout_hit) begin
        if (owner == OWN_LSU) begin
          o_lsu_rsp_valid <= 1'b1;
          o_lsu_rdata     <= (timeout_hit || wen_q) ? 32'd0 : mem.rdata;
          o_lsu_rsp_err   <= timeout_hit ? 1'b1 : mem.rsp_err;
        end else begin
          o_ifu_rsp_valid <= 1'b1;
          o_ifu_rdata     <= timeout_hit ? 32'd0 : mem.rdata;
          o_ifu_rsp_err   <= timeout_hit ? 1'b1 : mem.rsp_err;
        end
      end
    end
  end

  // Downstream request: valid only while in REQ, fields come from the latch
  // so they stay stable however long the memory stalls.
  assign mem.req_valid = (state == S_REQ);
  assign mem.addr      = addr_q;
  assign mem.wen       = wen_q;
  assign mem.wdata     = wdata_q;
  assign mem.wmask     = wmask_q;

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110006_mem_arbiter
//
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT=4.
// Memory-side behaviour is driven step by step from the single initial
// block; expected values are hand-computed constants. Expected arbitration
// order depends on whether ARB_RR_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_mem_arbiter;

  logic        i_clock;
  logic        i_reset;
  logic        i_ifu_req_valid;
  logic        o_ifu_req_ready;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_rsp_valid;
  logic [31:0] o_ifu_rdata;
  logic        o_ifu_rsp_err;
  logic        i_lsu_req_valid;
  logic        o_lsu_req_ready;
  logic [31:0] i_lsu_addr;
  logic        i_lsu_wen;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wmask;
  logic        o_lsu_rsp_valid;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_rsp_err;

  int          tests_run;
  int          tests_failed;
  logic [1:0]  tie_exp [3];

  ysyx_24110006_mem_arbiter_if mem_if ();

  ysyx_24110006_mem_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (8)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_ifu_req_valid (i_ifu_req_valid),
    .o_ifu_req_ready (o_ifu_req_ready),
    .i_ifu_addr      (i_ifu_addr),
    .o_ifu_rsp_valid (o_ifu_rsp_valid),
    .o_ifu_rdata     (o_ifu_rdata),
    .o_ifu_rsp_err   (o_ifu_rsp_err),
    .i_lsu_req_valid (i_lsu_req_valid),
    .o_lsu_req_ready (o_lsu_req_ready),
    .i_lsu_addr      (i_lsu_addr),
    .i_lsu_wen       (i_lsu_wen),
    .i_lsu_wdata     (i_lsu_wdata),
    .i_lsu_wmask     (i_lsu_wmask),
    .o_lsu_rsp_valid (o_lsu_rsp_valid),
    .o_lsu_rdata     (o_lsu_rdata),
    .o_lsu_rsp_err   (o_lsu_rsp_err),
    .mem             (mem_if)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifu_v, input logic [31:0] ifu_a,
                               input logic lsu_v, input logic [31:0] lsu_a,
                               input logic wen, input logic [31:0] wdata,
                               input logic [3:0] wmask);
    i_ifu_req_valid = ifu_v;
    i_ifu_addr      = ifu_a;
    i_lsu_req_valid = lsu_v;
    i_lsu_addr      = lsu_a;
    i_lsu_wen       = wen;
    i_lsu_wdata     = wdata;
    i_lsu_wmask     = wmask;
    #1;
  endtask

  // Called in the accept cycle: walks REQ (memory ready at once) and RSP
  // (memory answers at once) and returns in the response-strobe cycle.
  task automatic serveOne(input logic [31:0] exp_addr, input logic [31:0] rd,
                          input logic err);
    tick();
    checkOutput("req_valid_in_req", mem_if.req_valid, 1);
    checkOutput("req_addr", mem_if.addr, exp_addr);
    checkOutput("ready_low_when_busy", {o_ifu_req_ready, o_lsu_req_ready}, 0);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = rd;
    mem_if.rsp_err   = err;
    tick();
    mem_if.rsp_valid = 1'b0;
    mem_if.rdata     = 32'd0;
    mem_if.rsp_err   = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef ARB_RR_EN
    tie_exp[0] = 2'b01;
    tie_exp[1] = 2'b10;
    tie_exp[2] = 2'b01;
`else
    tie_exp[0] = 2'b01;
    tie_exp[1] = 2'b01;
    tie_exp[2] = 2'b01;
`endif
    mem_if.req_ready = 1'b0;
    mem_if.rsp_valid = 1'b0;
    mem_if.rdata     = 32'd0;
    mem_if.rsp_err   = 1'b0;
    i_reset          = 1'b1;

    // Reset: a request held during reset must not be granted.
    applyStimulus(1, 32'h0000_1000, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset_ifu_ready", o_ifu_req_ready, 0);
    checkOutput("reset_ifu_rsp_valid", o_ifu_rsp_valid, 0);
    checkOutput("reset_mem_req_valid", mem_if.req_valid, 0);
    checkOutput("reset_mem_addr", mem_if.addr, 0);
    checkOutput("reset_lsu_rdata", o_lsu_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    i_reset = 1'b0;
    tick();

    // LSU store, memory stalls the request for 3 cycles.
    applyStimulus(0, 0, 1, 32'h0000_0100, 1, 32'h1234_5678, 4'b0011);
    checkOutput("store_grant", {o_ifu_req_ready, o_lsu_req_ready}, 2'b01);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("store_req_valid", mem_if.req_valid, 1);
      checkOutput("store_addr", mem_if.addr, 32'h0000_0100);
      checkOutput("store_wdata", mem_if.wdata, 32'h1234_5678);
      checkOutput("store_wen_wmask", {mem_if.wen, mem_if.wmask}, 5'b1_0011);
      tick();
    end
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    checkOutput("store_req_dropped", mem_if.req_valid, 0);
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = 32'hFFFF_FFFF;
    tick();
    mem_if.rsp_valid = 1'b0;
    checkOutput("store_rsp_strobes", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b01);
    checkOutput("store_rdata_zero", o_lsu_rdata, 0);
    checkOutput("store_err", o_lsu_rsp_err, 0);
    tick();
    checkOutput("store_strobe_one_cycle", o_lsu_rsp_valid, 0);

    // IFU fetch with minimum latency: strobe lands three cycles after accept.
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0);
    checkOutput("fetch_grant", {o_ifu_req_ready, o_lsu_req_ready}, 2'b10);
    serveOne(32'h8000_0000, 32'hDEAD_BEEF, 0);
    checkOutput("fetch_rsp_strobes", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b10);
    checkOutput("fetch_rdata", o_ifu_rdata, 32'hDEAD_BEEF);
    checkOutput("fetch_err", o_ifu_rsp_err, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("fetch_strobe_one_cycle", o_ifu_rsp_valid, 0);

    // Both requesters held valid: three back-to-back ties, each new grant
    // overlapping the previous response strobe.
    applyStimulus(1, 32'h0000_2000, 1, 32'h0000_3000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checkOutput("tie_grant", {o_ifu_req_ready, o_lsu_req_ready}, tie_exp[k]);
      serveOne((tie_exp[k] == 2'b10) ? 32'h0000_2000 : 32'h0000_3000,
               32'h0000_00A0 + k, 0);
      checkOutput("tie_strobe", {o_ifu_rsp_valid, o_lsu_rsp_valid}, tie_exp[k]);
      checkOutput("tie_rdata",
                  (tie_exp[k] == 2'b10) ? o_ifu_rdata : o_lsu_rdata,
                  32'h0000_00A0 + k);
    end
    applyStimulus(1, 32'h0000_2000, 0, 0, 0, 0, 0);
    checkOutput("tie_tail_grant", {o_ifu_req_ready, o_lsu_req_ready}, 2'b10);
    serveOne(32'h0000_2000, 32'h0000_00B0, 0);
    checkOutput("tie_tail_strobe", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b10);
    checkOutput("tie_tail_rdata", o_ifu_rdata, 32'h0000_00B0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Timeout: LSU load, memory accepts but never answers for 4 RSP cycles.
    applyStimulus(0, 0, 1, 32'h0000_0400, 0, 0, 0);
    checkOutput("to_grant", o_lsu_req_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_no_early_strobe", o_lsu_rsp_valid, 0);
      tick();
    end
    checkOutput("to_strobe", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b01);
    checkOutput("to_err", o_lsu_rsp_err, 1);
    checkOutput("to_rdata", o_lsu_rdata, 0);
    // Drain: a new IFU request waits, the late response is swallowed.
    applyStimulus(1, 32'h0000_0500, 0, 0, 0, 0, 0);
    checkOutput("drain_no_grant", o_ifu_req_ready, 0);
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = 32'h0000_0BAD;
    tick();
    mem_if.rsp_valid = 1'b0;
    checkOutput("drain_discard", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b00);
    checkOutput("post_drain_grant", o_ifu_req_ready, 1);
    serveOne(32'h0000_0500, 32'hCAFE_F00D, 0);
    checkOutput("post_drain_strobe", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b10);
    checkOutput("post_drain_rdata", o_ifu_rdata, 32'hCAFE_F00D);
    checkOutput("post_drain_err", o_ifu_rsp_err, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();

    // Bus error on an LSU load leaves the IFU outputs untouched.
    applyStimulus(0, 0, 1, 32'h0000_0600, 0, 0, 0);
    serveOne(32'h0000_0600, 32'h1111_2222, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("err_strobe", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b01);
    checkOutput("err_lsu_err", o_lsu_rsp_err, 1);
    checkOutput("err_lsu_rdata", o_lsu_rdata, 32'h1111_2222);
    checkOutput("err_ifu_rdata_kept", o_ifu_rdata, 32'hCAFE_F00D);
    checkOutput("err_ifu_err_kept", o_ifu_rsp_err, 0);
    tick();

    // Reset while waiting in RSP: abort, clear, no strobe afterwards.
    applyStimulus(1, 32'h0000_0700, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checkOutput("rst_mid_strobes", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b00);
    checkOutput("rst_mid_ifu_rdata", o_ifu_rdata, 0);
    checkOutput("rst_mid_lsu_rdata", o_lsu_rdata, 0);
    checkOutput("rst_mid_lsu_err", o_lsu_rsp_err, 0);
    checkOutput("rst_mid_mem_valid", mem_if.req_valid, 0);
    checkOutput("rst_mid_mem_addr", mem_if.addr, 0);
    mem_if.rsp_valid = 1'b1;
    mem_if.rdata     = 32'h5555_5555;
    tick();
    mem_if.rsp_valid = 1'b0;
    checkOutput("rst_mid_late_rsp_ignored", {o_ifu_rsp_valid, o_lsu_rsp_valid}, 2'b00);
    applyStimulus(1, 32'h0000_0800, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_idle_grant", o_ifu_req_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
